// File: rtl/shake_input_buffer.sv
// Collects 64-bit message words into one SHAKE rate block, applies domain/final padding,
// and holds the finished block for the permute FSM until it is cleared.
module shake_input_buffer #(
  parameter int          RATE_WORDS = 17,
  parameter logic [7:0]  DOMAIN_PAD = 8'h1F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              data_in,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic                     data_last,
  input  logic [3:0]               data_len,
  output logic [64*RATE_WORDS-1:0] block_out,
  output logic                     input_buffer_ready,
  output logic                     last_block_in_input_buffer,
  input  logic                     input_buffer_ready_clr,
  input  logic                     last_block_in_buffer_clr
);

  localparam int            WW       = $clog2(RATE_WORDS);
  localparam logic [WW-1:0] LAST_IDX = WW'(RATE_WORDS - 1);
  localparam logic [WW-1:0] ONE      = WW'(1);

  typedef enum logic [1:0] {FILL, HOLD, RELEASE, PADBLK} state_t;

  state_t        state, state_d;
  logic [63:0]   blk   [RATE_WORDS];
  logic [63:0]   blk_d [RATE_WORDS];
  logic [WW-1:0] wcnt, wcnt_d;
  logic          pad_pending, pad_d;
  logic          last_q, last_d;
  logic [63:0]   fw;
  logic          take;
  logic          len_full;

  assign take     = data_valid && data_ready;
  assign len_full = (data_len >= 4'd8);

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      FILL:    if (take && (data_last || wcnt == LAST_IDX)) state_d = HOLD;
      HOLD:    if (input_buffer_ready_clr) state_d = RELEASE;
      RELEASE: state_d = pad_pending ? PADBLK : FILL;
      PADBLK:  state_d = HOLD;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    data_ready                 = (state == FILL);
    input_buffer_ready         = (state == HOLD);
    last_block_in_input_buffer = last_q;
  end

  // Block update: word capture and padding in FILL, zeroing on RELEASE exit, pad-only block in PADBLK.
  always_comb begin
    blk_d  = blk;
    wcnt_d = wcnt;
    pad_d  = pad_pending;
    last_d = last_q;
    fw     = '0;
    case (state)
      FILL: begin
        if (take) begin
          wcnt_d = (wcnt == LAST_IDX) ? '0 : wcnt + ONE;
          if (!data_last) begin
            blk_d[wcnt] = data_in;
            last_d      = 1'b0;
          end else begin
            wcnt_d = '0;
            for (int i = 0; i < 8; i++) begin
              if (4'(i) < data_len)       fw[8*i +: 8] = data_in[8*i +: 8];
              else if (4'(i) == data_len) fw[8*i +: 8] = DOMAIN_PAD;
            end
            blk_d[wcnt] = fw;
            if (!len_full) begin
              blk_d[RATE_WORDS-1][63:56] = blk_d[RATE_WORDS-1][63:56] | 8'h80;
              last_d = 1'b1;
            end else if (wcnt != LAST_IDX) begin
              blk_d[wcnt + ONE][7:0]     = DOMAIN_PAD;
              blk_d[RATE_WORDS-1][63:56] = blk_d[RATE_WORDS-1][63:56] | 8'h80;
              last_d = 1'b1;
            end else begin
              // Full block with no room for padding: a pad-only block follows after release.
              last_d = 1'b0;
              pad_d  = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        if (input_buffer_ready_clr || last_block_in_buffer_clr) last_d = 1'b0;
      end
      RELEASE: begin
        for (int k = 0; k < RATE_WORDS; k++) blk_d[k] = '0;
      end
      PADBLK: begin
        blk_d[0][7:0]              = DOMAIN_PAD;
        blk_d[RATE_WORDS-1][63:56] = blk_d[RATE_WORDS-1][63:56] | 8'h80;
        pad_d  = 1'b0;
        last_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RATE_WORDS; k++) blk[k] <= '0;
      wcnt        <= '0;
      pad_pending <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      blk         <= blk_d;
      wcnt        <= wcnt_d;
      pad_pending <= pad_d;
      last_q      <= last_d;
    end
  end

  for (genvar k = 0; k < RATE_WORDS; k++) begin : g_flat
    assign block_out[64*k +: 64] = blk[k];
  end

endmodule

// File: tb/tb_shake_input_buffer.sv
// Scoreboard bench for shake_input_buffer: a byte-level SHAKE padding model predicts every
// block, the expectations are queued at send time and compared when the buffer presents a block.
module tb_shake_input_buffer;

  localparam int RW = 17;
  localparam int BB = 8 * RW;
  localparam int BW = 64 * RW;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   data_in = '0;
  logic          data_valid = 1'b0;
  logic          data_ready;
  logic          data_last = 1'b0;
  logic [3:0]    data_len = '0;
  logic [BW-1:0] block_out;
  logic          input_buffer_ready;
  logic          last_block_in_input_buffer;
  logic          input_buffer_ready_clr = 1'b0;
  logic          last_block_in_buffer_clr = 1'b0;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  shake_input_buffer #(.RATE_WORDS(RW), .DOMAIN_PAD(8'h1F)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .data_in                    (data_in),
    .data_valid                 (data_valid),
    .data_ready                 (data_ready),
    .data_last                  (data_last),
    .data_len                   (data_len),
    .block_out                  (block_out),
    .input_buffer_ready         (input_buffer_ready),
    .last_block_in_input_buffer (last_block_in_input_buffer),
    .input_buffer_ready_clr     (input_buffer_ready_clr),
    .last_block_in_buffer_clr   (last_block_in_buffer_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached (got running, want finished)");
    $fatal(1, "[TB] watchdog");
  end

  // Reference padding: append domain byte, zero-fill to a rate multiple, OR 0x80 into the final byte.
  task automatic push_expected(input byte_q_t msg);
    byte_q_t p;
    int      nblk;
    exp_t    e;
    p = msg;
    p.push_back(8'h1F);
    while (p.size() % BB != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] | 8'h80;
    nblk = p.size() / BB;
    for (int b = 0; b < nblk; b++) begin
      e.data = '0;
      for (int i = 0; i < BB; i++) e.data[8*i +: 8] = p[b*BB + i];
      e.last = (b == nblk - 1);
      sb.push_back(e);
    end
  endtask

  task automatic rand_msg(input int n, output byte_q_t msg);
    msg = {};
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  // Entered just after a rising edge; returns just after the edge that transferred the word.
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] len);
    int n;
    data_in    = d;
    data_last  = last;
    data_len   = len;
    data_valid = 1'b1;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      if (data_ready) break;
    end
    if (n == 400) begin
      checks++;
      $display("[TB] FAIL send_timeout: data_ready got 0, want 1 within 400 cycles");
    end
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    data_last  = 1'b0;
    data_len   = '0;
    data_in    = '0;
  endtask

  task automatic send_msg(input byte_q_t msg);
    int n, nw;
    logic [63:0] d;
    logic [3:0]  len;
    n   = msg.size();
    nw  = (n == 0) ? 1 : (n + 7) / 8;
    len = 4'(n - 8 * (nw - 1));
    for (int w = 0; w < nw; w++) begin
      d = '0;
      for (int b = 0; b < 8; b++) begin
        if (8*w + b < n) d[8*b +: 8] = msg[8*w + b];
        else             d[8*b +: 8] = 8'hEE;
      end
      send_word(d, w == nw - 1, (w == nw - 1) ? len : 4'd0);
    end
  endtask

  // Waits for a held block, compares it with the scoreboard head, then takes it with both clears.
  task automatic consume_block(input string name);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!input_buffer_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!input_buffer_ready) begin
      $display("[TB] FAIL %s_ready_timeout: input_buffer_ready got 0, want 1", name);
      return;
    end
    passes++;
    checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL %s_unexpected: got a block, want none queued", name);
      return;
    end
    passes++;
    e = sb.pop_front();
    checks++;
    if (block_out !== e.data)
      $display("[TB] FAIL %s_block: got %h want %h", name, block_out, e.data);
    else passes++;
    checks++;
    if (last_block_in_input_buffer !== e.last)
      $display("[TB] FAIL %s_last: got %b want %b", name, last_block_in_input_buffer, e.last);
    else passes++;
    checks++;
    if (data_ready !== 1'b0)
      $display("[TB] FAIL %s_hold_data_ready: got %b want 0", name, data_ready);
    else passes++;
    input_buffer_ready_clr   = 1'b1;
    last_block_in_buffer_clr = e.last;
    @(posedge clk);
    #1;
    input_buffer_ready_clr   = 1'b0;
    last_block_in_buffer_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== 1'b0)
      $display("[TB] FAIL %s_flags_after_clr: got %b%b want 00", name,
               input_buffer_ready, last_block_in_input_buffer);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (block_out !== '0 || input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== 1'b0
        || data_ready !== 1'b1)
      $display("[TB] FAIL reset_state: got ready=%b last=%b dready=%b block_nonzero=%b want 0 0 1 0",
               input_buffer_ready, last_block_in_input_buffer, data_ready, |block_out);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty();
    byte_q_t m;
    m = {};
    push_expected(m);
    send_msg(m);
    consume_block("empty");
  endtask

  task automatic test_three_byte();
    byte_q_t m;
    m = {8'h61, 8'h62, 8'h63};
    push_expected(m);
    send_msg(m);
    @(negedge clk);
    checks++;
    if (input_buffer_ready !== 1'b1)
      $display("[TB] FAIL three_byte_latency: ready got %b want 1 one cycle after transfer",
               input_buffer_ready);
    else passes++;
    checks++;
    if (block_out[31:0] !== 32'h1F636261)
      $display("[TB] FAIL three_byte_word0: got %h want 1f636261", block_out[31:0]);
    else passes++;
    @(posedge clk);
    #1;
    consume_block("three_byte");
  endtask

  task automatic test_full_then_pad();
    byte_q_t m;
    rand_msg(BB, m);
    push_expected(m);
    fork
      send_msg(m);
      begin
        consume_block("full_data");
        consume_block("full_padblk");
      end
    join
  endtask

  task automatic test_seven_tail();
    byte_q_t m;
    rand_msg(BB - 1, m);
    push_expected(m);
    send_msg(m);
    @(negedge clk);
    checks++;
    if (block_out[BW-1 -: 8] !== 8'h9F)
      $display("[TB] FAIL seven_tail_byte135: got %h want 9f", block_out[BW-1 -: 8]);
    else passes++;
    @(posedge clk);
    #1;
    consume_block("seven_tail");
  endtask

  task automatic test_handshake();
    byte_q_t m;
    exp_t    e;
    rand_msg(20, m);
    push_expected(m);
    send_msg(m);
    e = sb.pop_front();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (data_ready !== 1'b0 || input_buffer_ready !== 1'b1 || block_out !== e.data)
        $display("[TB] FAIL hs_hold_c%0d: got dready=%b ready=%b block_ok=%b want 0 1 1",
                 c, data_ready, input_buffer_ready, block_out === e.data);
      else passes++;
    end
    last_block_in_buffer_clr = 1'b1;
    @(posedge clk);
    #1;
    last_block_in_buffer_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (last_block_in_input_buffer !== 1'b0 || input_buffer_ready !== 1'b1)
      $display("[TB] FAIL hs_last_clr_only: got last=%b ready=%b want 0 1",
               last_block_in_input_buffer, input_buffer_ready);
    else passes++;
    input_buffer_ready_clr = 1'b1;
    @(posedge clk);
    #1;
    input_buffer_ready_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (block_out !== e.data || input_buffer_ready !== 1'b0 || data_ready !== 1'b0)
      $display("[TB] FAIL hs_release: got block_ok=%b ready=%b dready=%b want 1 0 0",
               block_out === e.data, input_buffer_ready, data_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || block_out !== '0)
      $display("[TB] FAIL hs_refill: got dready=%b block_nonzero=%b want 1 0",
               data_ready, |block_out);
    else passes++;
    input_buffer_ready_clr   = 1'b1;
    last_block_in_buffer_clr = 1'b1;
    @(posedge clk);
    #1;
    input_buffer_ready_clr   = 1'b0;
    last_block_in_buffer_clr = 1'b0;
    @(negedge clk);
    checks++;
    if (data_ready !== 1'b1 || input_buffer_ready !== 1'b0 || block_out !== '0)
      $display("[TB] FAIL hs_clr_in_fill: got dready=%b ready=%b block_nonzero=%b want 1 0 0",
               data_ready, input_buffer_ready, |block_out);
    else passes++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    byte_q_t m;
    for (int w = 0; w < 5; w++) send_word({$urandom, $urandom}, 1'b0, 4'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (block_out !== '0 || input_buffer_ready !== 1'b0 || last_block_in_input_buffer !== 1'b0
        || data_ready !== 1'b1)
      $display("[TB] FAIL reset_mid_state: got ready=%b last=%b dready=%b block_nonzero=%b want 0 0 1 0",
               input_buffer_ready, last_block_in_input_buffer, data_ready, |block_out);
    else passes++;
    @(posedge clk);
    #1;
    m = {8'hAB};
    push_expected(m);
    send_msg(m);
    consume_block("reset_mid_msg");
  endtask

  task automatic test_back_to_back();
    byte_q_t m1, m2;
    rand_msg(10, m1);
    rand_msg(200, m2);
    push_expected(m1);
    push_expected(m2);
    fork
      begin
        send_msg(m1);
        send_msg(m2);
      end
      begin
        consume_block("b2b_m1");
        consume_block("b2b_m2_b0");
        consume_block("b2b_m2_b1");
      end
    join
    checks++;
    if (sb.size() != 0)
      $display("[TB] FAIL b2b_drain: got %0d blocks left want 0", sb.size());
    else passes++;
  endtask

  initial begin
    $display("[TB] shake_input_buffer bench start");
    test_reset();
    test_empty();
    test_three_byte();
    test_full_then_pad();
    test_seven_tail();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
